// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for the pipelined MIPS core.
// A shift-register scoreboard tracks in-flight destinations across the post-decode stages.
module fwd_hazard_unit #(
  parameter int unsigned NREAD     = 2,
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned REGBITS   = 5,
  parameter int unsigned ALU_READY = 2,
  parameter int unsigned LD_READY  = 3,
  parameter int unsigned CNTW      = 16,
  localparam int unsigned SELW     = $clog2(NSTAGE + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     advance,
  input  logic                     squash,
  input  logic                     id_valid,
  input  logic                     id_wen,
  input  logic                     id_load,
  input  logic [REGBITS-1:0]       id_dest,
  input  logic [NREAD*REGBITS-1:0] id_src,
  input  logic [NREAD-1:0]         id_src_used,
  output logic                     stall,
  output logic [NREAD*SELW-1:0]    fwd_sel,
  output logic                     ex_valid,
  output logic [CNTW-1:0]          stall_count
);

  typedef struct packed {
    logic               valid;
    logic               wen;
    logic               load;
    logic [REGBITS-1:0] dest;
  } entry_t;

  entry_t                sb [1:NSTAGE];
  logic [NREAD-1:0]      hazard;
  logic [NREAD*SELW-1:0] cand;
  logic                  issue;

  // Entries are scanned oldest to youngest so the youngest match is the one kept.
  always_comb begin
    int unsigned        kk;
    logic               found;
    logic               ldk;
    logic [REGBITS-1:0] src;
    hazard = '0;
    cand   = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      src   = id_src[p*REGBITS +: REGBITS];
      found = 1'b0;
      ldk   = 1'b0;
      kk    = 0;
      for (int unsigned k = NSTAGE; k >= 1; k--) begin
        if (sb[k].valid && sb[k].wen && (sb[k].dest == src) && (src != '0)) begin
          found = 1'b1;
          kk    = k;
          ldk   = sb[k].load;
        end
      end
      if (id_src_used[p] && found && (kk + 1 <= NSTAGE)) begin
        if (kk + 1 >= (ldk ? LD_READY : ALU_READY))
          cand[p*SELW +: SELW] = SELW'(kk + 1);
        else
          hazard[p] = 1'b1;
      end
    end
  end

  assign stall    = id_valid && !squash && (|hazard);
  assign issue    = id_valid && !squash && !stall;
  assign ex_valid = sb[1].valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 1; k <= NSTAGE; k++) sb[k] <= '0;
      fwd_sel     <= '0;
      stall_count <= '0;
    end else if (advance) begin
      for (int unsigned k = NSTAGE; k > 1; k--) sb[k] <= sb[k-1];
      if (issue)
        sb[1] <= '{valid: 1'b1, wen: (id_wen && (id_dest != '0)), load: id_load, dest: id_dest};
      else
        sb[1] <= '0;
      fwd_sel <= issue ? cand : '0;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations at default parameters.
module tb_fwd_hazard_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        advance;
  logic        squash;
  logic        id_valid;
  logic        id_wen;
  logic        id_load;
  logic [4:0]  id_dest;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic        ex_valid;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  fwd_hazard_unit #(
    .NREAD(2), .NSTAGE(3), .REGBITS(5), .ALU_READY(2), .LD_READY(3), .CNTW(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .advance(advance), .squash(squash),
    .id_valid(id_valid), .id_wen(id_wen), .id_load(id_load), .id_dest(id_dest),
    .id_src(id_src), .id_src_used(id_src_used),
    .stall(stall), .fwd_sel(fwd_sel), .ex_valid(ex_valid), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic wen, input logic ld, input logic [4:0] dest,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    id_valid = v; id_wen = wen; id_load = ld; id_dest = dest;
    id_src = {s1, s0}; id_src_used = used;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    repeat (3) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; advance = 1'b1; squash = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    #2;
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_fwd_sel", 32'(fwd_sel), 0);
    check("rst_count", 32'(stall_count), 0);
    check("rst_stall", 32'(stall), 0);
    @(negedge CLK) nRST = 1'b1;
    tick();

    // 1: ALU r3 then consumer on port 0
    set_id(1, 1, 0, 3, 0, 0, 2'b00); tick();
    check("s1_ex_valid", 32'(ex_valid), 1);
    set_id(1, 0, 0, 0, 3, 0, 2'b01); #1;
    check("s1_stall", 32'(stall), 0);
    tick();
    check("s1_fwd_sel", 32'(fwd_sel), 32'h2);
    flush();

    // 2: load-use on port 1
    set_id(1, 1, 1, 5, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 0, 5, 2'b10); #1;
    check("s2_stall", 32'(stall), 1);
    tick();
    check("s2_bubble", 32'(ex_valid), 0);
    check("s2_count", 32'(stall_count), 1);
    #1;
    check("s2_retry_stall", 32'(stall), 0);
    tick();
    check("s2_fwd_sel", 32'(fwd_sel), 32'hC);
    check("s2_ex_valid", 32'(ex_valid), 1);
    flush();

    // 3a: producer at entry 2
    set_id(1, 1, 0, 4, 0, 0, 2'b00); tick();
    set_id(0, 0, 0, 0, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 4, 0, 2'b01); #1;
    check("s3a_stall", 32'(stall), 0);
    tick();
    check("s3a_fwd_sel", 32'(fwd_sel), 32'h3);
    flush();

    // 3b: producer at entry 3 -> write-through
    set_id(1, 1, 0, 6, 0, 0, 2'b00); tick();
    set_id(0, 0, 0, 0, 0, 0, 2'b00); tick(); tick();
    set_id(1, 0, 0, 0, 6, 0, 2'b01); #1;
    check("s3b_stall", 32'(stall), 0);
    tick();
    check("s3b_fwd_sel", 32'(fwd_sel), 0);
    check("s3b_ex_valid", 32'(ex_valid), 1);
    flush();

    // 3c: r0 never forwards
    set_id(1, 1, 0, 0, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 0, 0, 2'b11); #1;
    check("s3c_stall", 32'(stall), 0);
    tick();
    check("s3c_fwd_sel", 32'(fwd_sel), 0);
    flush();

    // 4: youngest of two r7 writers wins
    set_id(1, 1, 1, 7, 0, 0, 2'b00); tick();
    set_id(1, 1, 0, 7, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 7, 7, 2'b11); #1;
    check("s4_stall", 32'(stall), 0);
    tick();
    check("s4_fwd_sel", 32'(fwd_sel), 32'hA);
    flush();

    // 5: load-use held by advance=0
    set_id(1, 1, 1, 9, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 9, 0, 2'b01); #1;
    check("s5_stall", 32'(stall), 1);
    advance = 1'b0;
    repeat (4) begin
      tick();
      check("s5_hold_stall", 32'(stall), 1);
      check("s5_hold_ex_valid", 32'(ex_valid), 1);
      check("s5_hold_count", 32'(stall_count), 1);
      check("s5_hold_fwd_sel", 32'(fwd_sel), 0);
    end
    advance = 1'b1;
    tick();
    check("s5_count", 32'(stall_count), 2);
    check("s5_bubble", 32'(ex_valid), 0);
    #1;
    check("s5_retry_stall", 32'(stall), 0);
    tick();
    check("s5_fwd_sel", 32'(fwd_sel), 32'h3);
    check("s5_ex_valid", 32'(ex_valid), 1);
    flush();

    // 6: squash beats hazard, then asynchronous reset
    set_id(1, 1, 1, 10, 0, 0, 2'b00); tick();
    set_id(1, 0, 0, 0, 0, 10, 2'b10); #1;
    check("s6_hazard", 32'(stall), 1);
    squash = 1'b1; #1;
    check("s6_squash_stall", 32'(stall), 0);
    tick();
    check("s6_bubble", 32'(ex_valid), 0);
    check("s6_count", 32'(stall_count), 2);
    squash = 1'b0; #1;
    check("s6_retry_stall", 32'(stall), 0);
    tick();
    check("s6_fwd_sel", 32'(fwd_sel), 32'hC);
    check("s6_ex_valid", 32'(ex_valid), 1);
    #2 nRST = 1'b0;
    #1;
    check("s6_rst_ex_valid", 32'(ex_valid), 0);
    check("s6_rst_fwd_sel", 32'(fwd_sel), 0);
    check("s6_rst_count", 32'(stall_count), 0);
    check("s6_rst_stall", 32'(stall), 0);
    @(negedge CLK) nRST = 1'b1;
    set_id(1, 1, 0, 3, 0, 0, 2'b00);
    tick();
    check("s6_post_rst_issue", 32'(ex_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined MIPS core.
- Replaces ad-hoc per-case forwarding compares with a shift-register scoreboard of in-flight destination registers. The scoreboard spans NSTAGE post-decode stages.
- Computes stall at decode from the scoreboard, then registers per-read-port forwarding selects so they are valid when the instruction is in EX.
- Supports any number of read ports, pipeline depth and result-ready stage per instruction class.

Parameters:
- NREAD, 2, number of source-register read ports per instruction.
- NSTAGE, 3, tracked stages after decode. Entry 1 = EX, entry NSTAGE = WB.
- REGBITS, 5, register index width.
- ALU_READY, 2, first entry from which a non-load result can be forwarded.
- LD_READY, 3, first entry from which a load result can be forwarded. Constraint: ALU_READY <= LD_READY <= NSTAGE.
- CNTW, 16, stall counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- advance  in  1  pipeline enable. Low means a memory stall; all state holds.
- squash  in  1  branch/jump flush. The decode instruction is discarded.
- id_valid  in  1  decode slot holds a real instruction.
- id_wen  in  1  decode instruction writes a register.
- id_load  in  1  decode instruction is a load.
- id_dest  in  REGBITS  decode destination register.
- id_src  in  NREAD*REGBITS  packed source registers. Port p is at [p*REGBITS +: REGBITS].
- id_src_used  in  NREAD  port p source is actually read.
- stall  out  1  combinational: hold IF/ID and PC, insert a bubble into EX.
- fwd_sel  out  NREAD*SELW  registered, SELW = $clog2(NSTAGE+1). Per port: 0 = register-file/ID-EX value; k = forward from the result of entry k.
- ex_valid  out  1  entry 1 holds a real instruction.
- stall_count  out  CNTW  saturating count of hazard stall cycles.

Behaviour:
- Scoreboard: NSTAGE entries, each {valid, wen, load, dest}.
  - An issue with id_dest==0 stores wen=0.
  - An entry matches source s iff valid & wen & dest==s & s!=0.
- Hazard check (combinational, per port p with id_src_used[p]):
  - Take the youngest matching entry k (smallest k) over entries 1..NSTAGE.
  - When the consumer reaches EX, the producer will be at k+1.
  - If k+1 > NSTAGE, or no match: no hazard, candidate select 0. At k=NSTAGE, register-file write-through supplies the value.
  - Else ready = k+1 >= (load ? LD_READY : ALU_READY). Not ready means hazard; ready gives candidate select k+1.
- stall = id_valid & ~squash & (OR of hazards over all ports). stall is independent of advance.
- On the clock edge with advance=1:
  - Entries shift: entry k+1 <= entry k. Entry NSTAGE is retired.
  - Entry 1 <= issue of {id_wen, id_load, id_dest} with valid=1 when id_valid & ~stall & ~squash. Otherwise entry 1 is a bubble (all zero).
  - fwd_sel <= candidate selects when an issue occurs; otherwise all zero.
  - stall_count increments when stall=1 and saturates at all-ones.
- On the clock edge with advance=0: entries, fwd_sel and stall_count hold. stall continues to be evaluated against the held state.
- squash together with a hazard: squash wins. stall=0, a bubble enters, no count increment.
- Reset (asynchronous, including mid-operation): all entries invalid; fwd_sel=0, ex_valid=0, stall_count=0.
  - stall is 0 while no entries are valid.
  - After nRST deasserts, the first advance edge issues normally.
- ex_valid = entry1.valid.
- Stall latency is 0 cycles (same cycle as decode). fwd_sel latency is 1 advancing edge.
- Register 0 never forwards or stalls.

Test Plan:
All scenarios use the default parameters.
1. Issue ALU write r3; on the next cycle decode reads r3 on port 0 -> stall=0; after the edge fwd_sel[0]=2.
2. Issue load to r5; next decode reads r5 on port 1 ->
   - stall=1 for exactly 1 cycle; entry 1 is a bubble (ex_valid=0); stall_count=1.
   - On the retry cycle stall=0; after the edge fwd_sel[1]=3.
3. Distance checks:
   - Producer r4 at entry 2 when the consumer decodes -> fwd_sel=3.
   - Producer at entry 3 -> fwd_sel=0.
   - Consumer reads r0 while an r0 issue is attempted -> fwd_sel=0, stall=0.
4. Writers to r7 at entries 1 (ALU) and 2 (load); consumer reads r7 on both ports -> both selects 2 (youngest wins); stall=0.
5. Load-use hazard pending with advance=0 held for 4 cycles ->
   - stall stays 1; entries and stall_count unchanged.
   - With advance=1: one stall edge, then the consumer issues.
6. Load-use hazard with squash=1 -> stall=0, bubble enters, count unchanged.
   - Then assert nRST=0 mid-stream -> ex_valid=0, fwd_sel=0, stall_count=0 immediately, without a clock edge.
